// File: rtl/niu32_debug_display.sv
// Debug word viewer: captures a debug word and shows it as paged 7-segment hex, with debounced page/freeze keys.
// Optional build macro DEBUG_BLINK_EN: blink the display while frozen.
module niu32_debug_display #(
  parameter int NUM_DIGITS      = 4,
  parameter int DATA_W          = 32,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int BLINK_CYCLES    = 12500000
) (
  input  logic                    CLOCK_50,
  input  logic                    RESET_N,
  input  logic                    DBG_VALID,
  input  logic [DATA_W-1:0]       DBG_DATA,
  output logic                    DBG_READY,
  input  logic                    KEY_PAGE,
  input  logic                    KEY_FREEZE,
  output logic [7*NUM_DIGITS-1:0] HEX,
  output logic [7:0]              LEDG,
  output logic [9:0]              LEDR
);

  localparam int NUM_PAGES = (DATA_W + 4*NUM_DIGITS - 1) / (4*NUM_DIGITS);
  localparam int NUM_NIBS  = DATA_W / 4;
  localparam int DB_W      = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;

  // key index 0 = page, 1 = freeze
  logic [1:0]      sync1, sync2, deb, flip, press;
  logic [DB_W-1:0] db_cnt [2];

  logic [DATA_W-1:0] data_q, data_nx;
  logic [3:0]        page_q, page_nx;
  logic              frozen_q, frozen_nx;
  logic              seen_q, seen_nx;
  logic [9:0]        cap_cnt, cap_cnt_nx;
  logic              capture;
  logic              blank_nx;
  logic [7*NUM_DIGITS-1:0] hex_nx;

  function automatic logic [6:0] seg7(input logic [3:0] n);
    case (n)
      4'h0: seg7 = 7'b1000000;
      4'h1: seg7 = 7'b1111001;
      4'h2: seg7 = 7'b0100100;
      4'h3: seg7 = 7'b0110000;
      4'h4: seg7 = 7'b0011001;
      4'h5: seg7 = 7'b0010010;
      4'h6: seg7 = 7'b0000010;
      4'h7: seg7 = 7'b1111000;
      4'h8: seg7 = 7'b0000000;
      4'h9: seg7 = 7'b0010000;
      4'hA: seg7 = 7'b0001000;
      4'hB: seg7 = 7'b0000011;
      4'hC: seg7 = 7'b1000110;
      4'hD: seg7 = 7'b0100001;
      4'hE: seg7 = 7'b0000110;
      default: seg7 = 7'b0001110;
    endcase
  endfunction

  // A flip happens on the DEBOUNCE_CYCLES-th consecutive differing sample.
  always_comb begin
    for (int k = 0; k < 2; k++) begin
      flip[k]  = (sync2[k] != deb[k]) && (db_cnt[k] == DB_W'(DEBOUNCE_CYCLES - 1));
      press[k] = flip[k] & deb[k];
    end
  end

  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      sync1 <= 2'b11;
      sync2 <= 2'b11;
      deb   <= 2'b11;
      for (int k = 0; k < 2; k++) db_cnt[k] <= '0;
    end else begin
      sync1 <= {KEY_FREEZE, KEY_PAGE};
      sync2 <= sync1;
      for (int k = 0; k < 2; k++) begin
        if (sync2[k] == deb[k]) begin
          db_cnt[k] <= '0;
        end else if (flip[k]) begin
          db_cnt[k] <= '0;
          deb[k]    <= sync2[k];
        end else begin
          db_cnt[k] <= db_cnt[k] + 1'b1;
        end
      end
    end
  end

  always_comb begin
    capture    = DBG_VALID & DBG_READY;
    data_nx    = capture ? DBG_DATA : data_q;
    seen_nx    = seen_q | capture;
    cap_cnt_nx = capture ? cap_cnt + 10'd1 : cap_cnt;
    frozen_nx  = frozen_q ^ press[1];
    page_nx    = page_q;
    if (press[0])
      page_nx = (page_q == 4'(NUM_PAGES - 1)) ? 4'd0 : page_q + 4'd1;
  end

`ifdef DEBUG_BLINK_EN
  localparam int BL_W = (BLINK_CYCLES > 2) ? $clog2(BLINK_CYCLES) : 1;
  logic [BL_W-1:0] blink_cnt, blink_cnt_nx;
  logic            blink_ph, blink_ph_nx;

  // Counter and phase restart on every freeze entry and idle while unfrozen.
  always_comb begin
    blink_cnt_nx = '0;
    blink_ph_nx  = 1'b0;
    if (frozen_q && frozen_nx) begin
      if (blink_cnt == BL_W'(BLINK_CYCLES - 1)) begin
        blink_ph_nx = ~blink_ph;
      end else begin
        blink_cnt_nx = blink_cnt + 1'b1;
        blink_ph_nx  = blink_ph;
      end
    end
    blank_nx = frozen_nx & blink_ph_nx;
  end

  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      blink_cnt <= '0;
      blink_ph  <= 1'b0;
    end else begin
      blink_cnt <= blink_cnt_nx;
      blink_ph  <= blink_ph_nx;
    end
  end
`else
  always_comb blank_nx = 1'b0;
`endif

  // HEX is built from next-state values so a capture shows on the following cycle.
  always_comb begin
    hex_nx = '1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (seen_nx && !blank_nx && (int'(page_nx) * NUM_DIGITS + i) < NUM_NIBS)
        hex_nx[7*i +: 7] = seg7(4'(data_nx >> (4 * (int'(page_nx) * NUM_DIGITS + i))));
    end
  end

  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      data_q    <= '0;
      page_q    <= '0;
      frozen_q  <= 1'b0;
      seen_q    <= 1'b0;
      cap_cnt   <= '0;
      DBG_READY <= 1'b0;
      HEX       <= '1;
    end else begin
      data_q    <= data_nx;
      page_q    <= page_nx;
      frozen_q  <= frozen_nx;
      seen_q    <= seen_nx;
      cap_cnt   <= cap_cnt_nx;
      DBG_READY <= ~frozen_nx;
      HEX       <= hex_nx;
    end
  end

  assign LEDG = {page_q, 2'b00, seen_q, frozen_q};
  assign LEDR = cap_cnt;

endmodule

// File: tb/tb_niu32_debug_display.sv
// Scoreboard bench for niu32_debug_display (4 digits, 32-bit word, debounce 4, blink 8).
module tb_niu32_debug_display;

  localparam int ND = 4;
  localparam int DW = 32;

  logic          CLOCK_50 = 1'b0;
  logic          RESET_N;
  logic          DBG_VALID;
  logic [DW-1:0] DBG_DATA;
  logic          DBG_READY;
  logic          KEY_PAGE;
  logic          KEY_FREEZE;
  logic [7*ND-1:0] HEX;
  logic [7:0]    LEDG;
  logic [9:0]    LEDR;

  niu32_debug_display #(
    .NUM_DIGITS(ND), .DATA_W(DW), .DEBOUNCE_CYCLES(4), .BLINK_CYCLES(8)
  ) dut (
    .CLOCK_50(CLOCK_50), .RESET_N(RESET_N), .DBG_VALID(DBG_VALID),
    .DBG_DATA(DBG_DATA), .DBG_READY(DBG_READY), .KEY_PAGE(KEY_PAGE),
    .KEY_FREEZE(KEY_FREEZE), .HEX(HEX), .LEDG(LEDG), .LEDR(LEDR)
  );

  always #10 CLOCK_50 = ~CLOCK_50;

  typedef struct {
    logic [7*ND-1:0] hex;
    logic [9:0]      ledr;
    logic [7:0]      ledg;
    logic            rdy;
  } exp_t;

  exp_t exp_q[$];
  int   n_vec = 0;
  int   n_err = 0;

  logic [DW-1:0] m_data;
  logic [3:0]    m_page;
  logic          m_frozen, m_seen, m_ready;
  logic [9:0]    m_cnt;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [6:0] seg(input logic [3:0] n);
    logic [6:0] t [16] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                           7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                           7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
                           7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};
    return t[n];
  endfunction

  function automatic logic [7*ND-1:0] exp_hex();
    logic [7*ND-1:0] h = '1;
    for (int i = 0; i < ND; i++) begin
      int idx = int'(m_page) * ND + i;
      if (m_seen && idx < DW/4) h[7*i +: 7] = seg(4'(m_data >> (4*idx)));
    end
    return h;
  endfunction

  function automatic exp_t model_now();
    exp_t e;
    e.hex  = exp_hex();
    e.ledr = m_cnt;
    e.ledg = {m_page, 2'b00, m_seen, m_frozen};
    e.rdy  = m_ready;
    return e;
  endfunction

  task automatic cycle();
    @(posedge CLOCK_50);
    #1;
  endtask

  task automatic compare(input string tag, input exp_t e);
    chk({tag, "_hex"},  64'(HEX),       64'(e.hex));
    chk({tag, "_ledr"}, 64'(LEDR),      64'(e.ledr));
    chk({tag, "_ledg"}, 64'(LEDG),      64'(e.ledg));
    chk({tag, "_rdy"},  64'(DBG_READY), 64'(e.rdy));
  endtask

  task automatic pop_cmp(input string tag);
    if (exp_q.size() == 0) begin
      chk({tag, "_sb_empty"}, 64'(exp_q.size()), 64'd1);
    end else begin
      compare(tag, exp_q.pop_front());
    end
  endtask

  task automatic model_reset();
    m_data = '0; m_page = '0; m_frozen = 1'b0; m_seen = 1'b0; m_cnt = '0; m_ready = 1'b0;
  endtask

  // Offer one word for one cycle; expectation is pushed when driven, popped after the edge.
  task automatic capture(input logic [DW-1:0] d, input string tag);
    DBG_VALID = 1'b1;
    DBG_DATA  = d;
    if (m_ready) begin
      m_data = d;
      m_seen = 1'b1;
      m_cnt  = m_cnt + 10'd1;
    end
    exp_q.push_back(model_now());
    cycle();
    DBG_VALID = 1'b0;
    DBG_DATA  = $urandom;
    pop_cmp(tag);
  endtask

  task automatic press(input bit freeze, input int low_cycles, input string tag);
    if (freeze) KEY_FREEZE = 1'b0; else KEY_PAGE = 1'b0;
    repeat (low_cycles) cycle();
    KEY_FREEZE = 1'b1;
    KEY_PAGE   = 1'b1;
    repeat (10) cycle();
    if (low_cycles >= 4) begin
      if (freeze) m_frozen = ~m_frozen;
      else        m_page   = (m_page == 4'd1) ? 4'd0 : m_page + 4'd1;
    end
    m_ready = ~m_frozen;
    compare(tag, model_now());
  endtask

  initial begin
    logic [7*ND-1:0] held;
    int n_cap, n_blank, n_shown;
    RESET_N = 1'b0; DBG_VALID = 1'b0; DBG_DATA = '0;
    KEY_PAGE = 1'b1; KEY_FREEZE = 1'b1;
    model_reset();
    repeat (3) cycle();
    compare("reset", model_now());

    RESET_N = 1'b1;
    cycle();
    m_ready = 1'b1;
    compare("rdy_after_rst", model_now());

    capture(32'h1234ABCD, "cap_first");
    chk("digit0_d", 64'(HEX[6:0]), 64'(7'b0100001));
    chk("digit3_a", 64'(HEX[27:21]), 64'(7'b0001000));
    chk("ledg_02", 64'(LEDG), 64'h02);

    press(1'b0, 3, "page_short");
    press(1'b0, 10, "page_adv");
    chk("page1_digits", 64'(HEX), 64'({7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001}));
    press(1'b0, 10, "page_wrap");

    press(1'b1, 10, "freeze_on");
    capture(32'hFFFFFFFF, "cap_frozen");
    held = HEX;
    n_blank = 0; n_shown = 0;
    repeat (20) begin
      cycle();
`ifdef DEBUG_BLINK_EN
      if (HEX == '1) n_blank++; else if (HEX == held) n_shown++;
`else
      chk("steady_frozen", 64'(HEX), 64'(held));
`endif
    end
`ifdef DEBUG_BLINK_EN
    chk("blink_blank_seen", 64'(n_blank != 0), 64'd1);
    chk("blink_value_seen", 64'(n_shown != 0), 64'd1);
`endif
    press(1'b1, 10, "freeze_off");
    capture(32'h0BADF00D, "cap_unfrozen");

    n_cap = 1024 - int'(m_cnt);
    for (int i = 0; i < n_cap; i++) capture($urandom, "cap_loop");
    chk("ledr_wrap", 64'(LEDR), 64'd0);
    chk("seen_kept", 64'(LEDG[1]), 64'd1);

    // Capture, page press and freeze press land on the same edge.
    KEY_PAGE = 1'b0; KEY_FREEZE = 1'b0;
    repeat (5) cycle();
    DBG_VALID = 1'b1; DBG_DATA = 32'hCAFE5678;
    m_data = 32'hCAFE5678; m_seen = 1'b1; m_cnt = m_cnt + 10'd1;
    m_page = m_page + 4'd1; m_frozen = 1'b1; m_ready = 1'b0;
    exp_q.push_back(model_now());
    cycle();
    DBG_VALID = 1'b0;
    pop_cmp("simul");
    KEY_PAGE = 1'b1; KEY_FREEZE = 1'b1;
    repeat (10) cycle();
    compare("simul_settle", model_now());
    press(1'b1, 10, "simul_unfreeze");
    capture(32'h00C0FFEE, "cap_after_simul");

    // Reset mid-cycle while a page press is still debouncing.
    KEY_PAGE = 1'b0;
    repeat (4) cycle();
    #5 RESET_N = 1'b0;
    #1;
    model_reset();
    compare("async_reset", model_now());
    KEY_PAGE = 1'b1;
    cycle();
    RESET_N = 1'b1;
    cycle();
    m_ready = 1'b1;
    repeat (10) cycle();
    compare("rst_discard_db", model_now());
    capture(32'h89ABCDEF, "cap_post_rst");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
